// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared ALu: accepts one operation,
// runs it through the embedded ALu and returns a registered, tagged result.

module ALu #(
  parameter int n = 8
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [2:0]   OpCode,
  output logic [n-1:0] Result,
  output logic         C_out,
  output logic         C_flag,
  output logic         Z_flag
);
  logic [n:0] r;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    r = '0;
    case (OpCode)
      3'b000: r = {1'b0, A} + {1'b0, B};
      3'b001: r = {1'b0, A} - {1'b0, B};
      3'b010: r = {1'b0, A & B};
      3'b011: r = {1'b0, A | B};
      3'b100: r = {1'b0, A ^ B};
      3'b101: r = {{n{1'b0}}, (A > B)};
      3'b110: r = {A, 1'b0};
      3'b111: r = {B, 1'b0};
      default: r = '0;
    endcase
  end

  assign Result = r[n-1:0];
  assign C_out  = r[n];
  assign C_flag = (A > B);
  assign Z_flag = (r[n-1:0] == '0);
endmodule

module alu_arbiter #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [n-1:0] req0_A,
  input  logic [n-1:0] req0_B,
  input  logic [n-1:0] req1_A,
  input  logic [n-1:0] req1_B,
  input  logic [2:0]   req0_OpCode,
  input  logic [2:0]   req1_OpCode,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] Result,
  output logic         Z_flag,
  output logic         C_flag,
  output logic         C_out
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;

  logic         last_grant_q;
  logic [n-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic         id_q;
  logic         rsp_valid_q, rsp_id_q;
  logic [n-1:0] result_q;
  logic         z_q, cflag_q, cout_q;

  logic         grant_id, accept;
  logic [n-1:0] alu_result;
  logic         alu_cout, alu_cflag, alu_z;

  ALu #(.n(n)) u_alu (
    .A      (a_q),
    .B      (b_q),
    .OpCode (op_q),
    .Result (alu_result),
    .C_out  (alu_cout),
    .C_flag (alu_cflag),
    .Z_flag (alu_z)
  );

  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0_valid || req1_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_id   = req0_valid ? (req1_valid ? ~last_grant_q : 1'b0) : 1'b1;
    accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
  end

  // NOTE: datapath registers are reset too, so the response port reads all-zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      result_q     <= '0;
      z_q          <= 1'b0;
      cflag_q      <= 1'b0;
      cout_q       <= 1'b0;
    end else begin
      if (accept) begin
        a_q          <= grant_id ? req1_A : req0_A;
        b_q          <= grant_id ? req1_B : req0_B;
        op_q         <= grant_id ? req1_OpCode : req0_OpCode;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        result_q    <= alu_result;
        z_q         <= alu_z;
        cflag_q     <= alu_cflag;
        cout_q      <= alu_cout;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign Result    = result_q;
  assign Z_flag    = z_q;
  assign C_flag    = cflag_q;
  assign C_out     = cout_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared `n`-bit ALU (`ALu`). It accepts operation requests on two independent valid/ready ports and grants them round-robin. It captures the operands, runs one operation at a time through an embedded `ALu` instance, and returns a registered, tagged result with flags on a single valid/ready response port. It sits between the two issuing units and the ALU datapath.

## Interface
- `n`, 8, operand/result width (passed to the embedded `ALu`).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  requester x has an operation pending.
- `req0_ready`, `req1_ready`  out  1  requester x's operation is accepted this cycle.
- `req0_A`, `req0_B`, `req1_A`, `req1_B`  in  n  operands per requester.
- `req0_OpCode`, `req1_OpCode`  in  3  ALU opcode per requester.
- `rsp_valid`  out  1  response holds a valid result.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_id`  out  1  index of the requester that issued the operation.
- `Result`  out  n  registered ALU result.
- `Z_flag`, `C_flag`, `C_out`  out  1  registered ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `reqX_valid` is high, grant one requester.
  - Drive its `reqX_ready`=1 (combinational from the valids, IDLE state only).
  - Capture its `A`, `B`, `OpCode` and id into operand registers.
  - Go to EXEC.
- **EXEC**
  - The embedded `ALu` evaluates the captured operands.
  - At the clock edge, register `Result`, `Z_flag`, `C_flag`, `C_out` and `rsp_id`, and set `rsp_valid`=1.
  - Go to RESP.
- **RESP**
  - Hold all response outputs stable while `rsp_ready`=0.
  - On `rsp_valid && rsp_ready`, clear `rsp_valid` and go to IDLE.
- Both `reqX_ready` are 0 in EXEC and RESP. At most one `reqX_ready` is high in any cycle.
- **Arbitration**
  - A `last_grant` register updates on every accept.
  - When both requests are valid, grant the requester ≠ `last_grant`.
  - A single valid request is granted regardless of `last_grant`.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- Operand changes on a requester after its accept have no effect on the operation in flight.
- **ALU semantics** (all unsigned; `r` is the (n+1)-bit intermediate result):
  - 000 add: `r=A+B`.
  - 001 sub: `r=A-B`; `r[n]`=1 when A<B.
  - 010 AND, 011 OR, 100 XOR: `r[n]`=0.
  - 101 compare: `r=(A>B)` in bit 0.
  - 110 `r=A<<1`; 111 `r=B<<1` (`r[n]` is the shifted-out MSB).
  - `Result=r[n-1:0]`, `C_out=r[n]`.
  - `C_flag=(A>B)` for every opcode.
  - `Z_flag=(Result==0)`.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State goes to IDLE.
  - `rsp_valid`=0, `rsp_id`=0, `Result`=0, `Z_flag`=0, `C_flag`=0, `C_out`=0.
  - `last_grant`=1; operand registers are cleared.
  - `reqX_ready` are 0 while `rst_n`=0.
- Latency: accept edge T (valid&ready) → `rsp_valid` high in the cycle after edge T+1, i.e. two cycles after the accept.
- The next accept is possible in the cycle after the response handshake. Minimum issue interval is 3 cycles with `rsp_ready` tied high.
- Reset mid-operation (EXEC or RESP) discards the in-flight operation. No response is produced for it, and `last_grant` returns to 1.
- `rsp_ready` high outside RESP is ignored.
- Simultaneous response handshake and new request: the request waits in `valid` and is accepted in the following IDLE cycle.

## Test plan
- **Single add, back-to-back path.** Reset, then req0 A=8'hFF, B=8'h01, OpCode=000, `rsp_ready`=1.
  - Expect `req0_ready`=1 for one cycle.
  - Two cycles later: `rsp_valid`=1, `rsp_id`=0, `Result`=8'h00, `C_out`=1, `Z_flag`=1, `C_flag`=1.
- **Subtract with borrow.** req1 A=3, B=5, OpCode=001.
  - Expect `Result`=8'hFE, `C_out`=1, `C_flag`=0, `Z_flag`=0, `rsp_id`=1.
- **Round-robin.** Both requesters valid continuously with distinct XOR operands.
  - Expect grants in order 0,1,0,1 after reset, and `rsp_id` sequence 0,1,0,1.
  - One-sided traffic from req1 only is granted every 3 cycles.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles during RESP of A=8'h81, OpCode=110.
  - `Result`=8'h02 and `C_out`=1 stay stable throughout.
  - Both `reqX_ready`=0 while pending valids wait.
  - The response completes on the first `rsp_ready`=1.
- **Compare and shift-B.** A=7, B=7, OpCode=101: `Result`=0, `Z_flag`=1, `C_flag`=0. Then B=8'h40, OpCode=111: `Result`=8'h80, `C_out`=0.
- **Reset mid-EXEC.** Assert `rst_n`=0 during EXEC.
  - All outputs go to 0 immediately, with no response for the aborted operation.
  - After release, a tie is granted to requester 0.
